rs_corrector: RTL

Error-correction stage downstream of the RS(255,239) decoder. It buffers every received symbol while the decoder computes the error pattern. When the decoder presents an error symbol, the block XORs it into the matching buffered symbol and emits the corrected codeword stream with framing and message/parity marking.

---
 rtl/rs_corrector_if.sv | 40 ++++
 rtl/rs_corrector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rs_corrector_if.sv
// rs_corrector_if: symbol stream and status bundle around the RS error corrector.
//   master : drives the received stream (rx_data/rx_ena) and decoder errors
//            (err/err_valid); observes corrected stream and status.
//   slave  : the corrector itself.
//   rx_data/rx_ena       received symbol stream (same as fed to the decoder)
//   err/err_valid        decoder error symbols, one per cycle, codeword order
//   corr_data/corr_valid corrected symbol stream
//   corr_first/last/msg  framing: position 0, position N-1, message symbol
//   level                buffer occupancy (AW+1 bits)
//   overflow/underflow   sticky error flags
//   err_cnt              nonzero error symbols in last completed codeword
interface rs_corrector_if #(
    parameter int AW = 9
);
    logic [7:0]  rx_data;
    logic        rx_ena;
    logic [7:0]  err;
    logic        err_valid;
    logic [7:0]  corr_data;
    logic        corr_valid;
    logic        corr_first;
    logic        corr_last;
    logic        corr_msg;
    logic [AW:0] level;
    logic        overflow;
    logic        underflow;
    logic [7:0]  err_cnt;

    modport master (
        output rx_data, rx_ena, err, err_valid,
        input  corr_data, corr_valid, corr_first, corr_last, corr_msg,
               level, overflow, underflow, err_cnt
    );

    modport slave (
        input  rx_data, rx_ena, err, err_valid,
        output corr_data, corr_valid, corr_first, corr_last, corr_msg,
               level, overflow, underflow, err_cnt
    );
endinterface

// File: rtl/rs_corrector.sv
// rs_corrector: buffers received RS(255,239) symbols while the decoder works,
// then XORs each decoder error symbol into its buffered symbol and emits the
// corrected codeword with framing (first/last) and message/parity marking.
//   clk   positive-edge clock
//   clrn  asynchronous active-low reset (buffer contents are not cleared)
//   bus   rs_corrector_if.slave; see the interface for signal meanings
// Optional feature: define RS_CORR_STATS_EN to count nonzero error symbols per
// codeword on err_cnt; without it err_cnt is tied to 0.
//
// Read FSM:
//   state | meaning
//   IDLE  | pos == 0, no codeword being emitted
//   WORD  | codeword in progress, pos in 1..N-1
module rs_corrector #(
    parameter int N  = 255,
    parameter int T2 = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          clrn,
    rs_corrector_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE, WORD} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;
    logic          last_pos;
    logic [7:0]    pos;
    state_t        state;

    logic [7:0]    corr_data_q;
    logic          corr_valid_q;
    logic          corr_first_q;
    logic          corr_last_q;
    logic          corr_msg_q;
    logic          overflow_q;
    logic          underflow_q;

    // level never exceeds DEPTH, so its MSB alone marks the full condition.
    assign full     = level_q[AW];
    assign empty    = (level_q == '0);
    assign wr_ok    = bus.rx_ena && !full;
    assign rd_ok    = bus.err_valid && !empty;
    assign last_pos = (pos == 8'(N - 1));

    // Storage has no reset; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    // Pointers, occupancy, sticky flags and corrected data.
    // A read and a write never hit the same address in one cycle: that would
    // need level 0 (no read) or level DEPTH (no write).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            corr_data_q  <= 8'd0;
            corr_valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (bus.rx_ena && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.err_valid && empty) begin
                underflow_q <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            corr_valid_q <= rd_ok;
            if (rd_ok) begin
                corr_data_q <= mem[rd_ptr] ^ bus.err;
                rd_ptr      <= rd_ptr + AW'(1);
            end
        end
    end

    // Read FSM with codeword position and framing outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= IDLE;
            pos          <= 8'd0;
            corr_first_q <= 1'b0;
            corr_last_q  <= 1'b0;
            corr_msg_q   <= 1'b0;
        end else if (rd_ok) begin
            corr_first_q <= (pos == 8'd0);
            corr_last_q  <= last_pos;
            corr_msg_q   <= (pos < 8'(N - T2));
            pos          <= last_pos ? 8'd0 : pos + 8'd1;
            case (state)
                IDLE:    state <= last_pos ? IDLE : WORD;
                WORD:    state <= last_pos ? IDLE : WORD;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_CORR_STATS_EN
    logic [7:0] sym_cnt;
    logic [7:0] err_cnt_q;
    logic [7:0] cnt_next;

    // A read at position 0 starts a fresh count rather than accumulating.
    always_comb begin
        cnt_next = ((pos == 8'd0) ? 8'd0 : sym_cnt) + {7'd0, (bus.err != 8'd0)};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sym_cnt   <= 8'd0;
            err_cnt_q <= 8'd0;
        end else if (rd_ok) begin
            sym_cnt <= cnt_next;
            if (last_pos) begin
                err_cnt_q <= cnt_next;
            end
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.corr_data  = corr_data_q;
    assign bus.corr_valid = corr_valid_q;
    assign bus.corr_first = corr_first_q;
    assign bus.corr_last  = corr_last_q;
    assign bus.corr_msg   = corr_msg_q;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule
